mux4x1_tdm: RTL and testbench

Four-channel time-division multiplexer that merges four valid/ready input streams onto one output stream. Each output word carries a 2-bit channel tag (`out_sel`) matching the `{sel1,sel0}` encoding used by our 1:4 demultiplexers, so a downstream demux can route words back to their channels. The block is registered, uses round-robin arbitration by default, and sustains one transfer per cycle.

---
 rtl/mux4x1_tdm_pkg.sv | 24 ++
 rtl/mux4x1_tdm_arb.sv | 43 ++++
 rtl/mux4x1_tdm.sv | 98 +++++++++
 tb/tb_mux4x1_tdm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux4x1_tdm_pkg.sv
// Shared types and helpers for the 4:1 time-division multiplexer.
package mux4x1_tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  // Encodes a one-hot grant as a channel index; an all-zero grant maps to 0.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) begin
        idx = idx | SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4x1_tdm_arb.sv
// Combinational 4-way arbiter: round-robin from ptr, or fixed priority
// (channel 0 highest) when MUX4X1_TDM_FIXED_PRIO_EN is defined.
module rr_arbiter4
  import mux4x1_tdm_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt
);

`ifdef MUX4X1_TDM_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] cand;
  logic             found;

  // Walk ptr, ptr+1, ... modulo 4; the first requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mux4x1_tdm.sv
// Four-channel valid/ready TDM merger with a registered, channel-tagged output.
// Define MUX4X1_TDM_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mux4x1_tdm
  import mux4x1_tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_t            state;
  state_t            state_nxt;
  logic              load_en;
  logic              take;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  ptr;
  logic [WIDTH-1:0]  sel_data;

`ifdef MUX4X1_TDM_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= gnt_idx + SEL_W'(1);
    end
  end
`endif

  rr_arbiter4 u_arb (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign gnt_idx  = onehot_to_idx(gnt);
  assign load_en  = !out_valid || out_ready;
  assign in_ready = gnt & {NUM_CH{load_en && rst_n}};
  assign take     = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A same-cycle drain and refill keeps the register FULL with no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (take) state_nxt = ST_FULL;
      ST_FULL: begin
        if (take) begin
          state_nxt = ST_FULL;
        end else if (out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (take) begin
      out_data <= sel_data;
      out_sel  <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mux4x1_tdm.sv
// Self-checking bench for mux4x1_tdm: directed plan steps plus random traffic
// checked against a behavioural arbitration model.
module tb_mux4x1_tdm;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid;
  logic [3:0]     in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  bit       m_valid;
  bit [7:0] m_data;
  int       m_sel;
  int       m_ptr;

  mux4x1_tdm #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v);
    int start;
`ifdef MUX4X1_TDM_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_valid);
    chk({tag, ".out_data"}, out_data, m_data);
    chk({tag, ".out_sel"}, out_sel, m_sel);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    int g;
    logic [3:0] er;
    #1;
    g  = model_grant(in_valid);
    er = ((!m_valid || out_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk({tag, ".in_ready"}, in_ready, er);
    @(posedge clk);
    if (er != 0) begin
      m_valid = 1;
      m_data  = in_data[g*8 +: 8];
      m_sel   = g;
      m_ptr   = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    model_reset();
    @(negedge clk);
    #1;
    chk("reset.in_ready", in_ready, 4'b0000);
    check_outputs("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b0000;
    cycle("idle");

    in_valid = 4'b0100;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    cycle("single");
    in_valid = 4'b0000;
    cycle("single_drain");

    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 6; i++) cycle("allvalid");

    // Land on out_sel=1 then stall for five cycles.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("bp_load0");
    cycle("bp_load1");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle("backpressure");
    out_ready = 1'b1;
    cycle("bp_release");

    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) cycle("wrap");

    // Reset asserted between edges while FULL takes effect immediately.
    in_valid = 4'b1111;
    cycle("pre_async");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.in_ready", in_ready, 4'b0000);
    check_outputs("async");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_async");

    for (int n = 0; n < 400; n++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
